dance_round_ctrl: RTL
=====================

Name: dance_round_ctrl

Overview:
- Game-round sequencer for the boss dance game.
- Paces the boss pose generator on a divided tick and opens a timed response window per pose.
- Judges the player's pose against the boss's current pose and emits the `right` strobe that advances the boss.
- Keeps a two-digit BCD score and a miss count; declares win or game-over. Sits between player input decode, the boss block and the seven-segment/score display.

Parameters:
- TICK_DIV, 100000, clk cycles per game tick (must be >= 2)
- SHOW_TICKS, 8, ticks a new pose is displayed before the window opens (>= 1)
- WINDOW_TICKS, 16, ticks the player has to respond (>= 1)
- MAX_MISS, 3, misses that end the game (1..3)
- WIN_SCORE, 99, score (decimal, 1..99) that wins the game

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; starts or restarts a game
- player_valid  in  1  single-cycle pulse; player has committed a pose
- player_pose  in  2  player pose, same encoding as the boss pose
- boss_pose  in  2  boss current pose (UP=11, DOWN=00, LEFTUP=10, RIGHTUP=01)
- right  out  1  single-cycle pulse on a correct match; drives the boss advance input
- pose_advance  out  1  single-cycle pulse each time a round ends, hit or miss
- score_ones  out  4  BCD ones digit
- score_tens  out  4  BCD tens digit
- miss_count  out  2  misses so far
- phase  out  3  current FSM state encoding
- game_over  out  1  high in DONE
- win  out  1  high in DONE when the game ended on WIN_SCORE

Behaviour:
Reset:
- All outputs 0, state IDLE, tick divider and tick counter 0.
- Reset overrides every other input on the same edge, mid-game included.

Tick generation:
- Divider counts 0..TICK_DIV-1 and emits a one-cycle `tick` at TICK_DIV-1.
- The divider is cleared on every state entry, so each state's first tick arrives exactly TICK_DIV cycles after entry.

States (phase encoding):
- IDLE=0
  - Outputs held at 0.
  - `start` moves to SHOW on the next edge and clears score and misses.
- SHOW=1
  - Count ticks; after the SHOW_TICKS-th tick, go to WINDOW.
  - `player_valid` is ignored in SHOW.
- WINDOW=2
  - First `player_valid` with player_pose==boss_pose: `right`=1 for the following cycle, score increments, go to RESULT.
  - First `player_valid` with a mismatch: miss_count increments, go to RESULT.
  - No valid by the WINDOW_TICKS-th tick: miss, go to RESULT.
  - `player_valid` coincident with the timeout tick is judged as a valid response (valid wins).
- RESULT=3
  - Exactly one cycle; `pose_advance`=1.
  - Go to DONE with win=1 if score == WIN_SCORE.
  - Else go to DONE with win=0 if miss_count == MAX_MISS.
  - Else go to SHOW.
- DONE=4
  - game_over=1; score, misses and win held.
  - `start` returns to SHOW with score and misses cleared (win/game_over drop on that edge).

Start rules:
- `start` in SHOW, WINDOW or RESULT restarts the game: clear score and misses, go to SHOW.

Arithmetic:
- BCD score: ones 9 -> 0 with tens+1.
- The score never exceeds 99 (saturates; WIN_SCORE ≤ 99 ends the game first).
- miss_count saturates at 3.

Latency:
- `right` and the score update appear one cycle after the judging `player_valid` edge.
- `pose_advance` appears on the cycle after that.

Decomposition:
- Shared package:
  - pose encodings UP/DOWN/LEFTUP/RIGHTUP (the same values the boss block uses)
  - phase state encodings
  - BCD digit width constant
- One sub-module, `tick_gen`: TICK_DIV divider with synchronous clear, one-cycle tick output.
- The BCD score counter stays inline.

Test Plan:
All scenarios use TICK_DIV=4, SHOW_TICKS=2, WINDOW_TICKS=3, MAX_MISS=3, WIN_SCORE=3.
1. Hit: reset, start, then player_valid with player_pose=boss_pose=2'b11 two cycles into WINDOW.
   - phase 0->1 (8 cycles) ->2.
   - right pulses one cycle later, score_ones=1; pose_advance the cycle after; phase returns to 1.
2. Wrong pose: player_pose=01 vs boss_pose=10 in WINDOW -> right stays 0, miss_count=1, pose_advance pulses once.
3. Timeout: no player_valid in WINDOW -> exactly 12 cycles after WINDOW entry, miss_count increments and pose_advance pulses.
4. Valid on timeout tick: player_valid matching on the 12th WINDOW cycle -> scored as a hit, miss_count unchanged.
5. End conditions:
   - Three hits -> phase=4, game_over=1, win=1, score 0/3.
   - Separately, three misses -> game_over=1, win=0, miss_count=3.
   - start in DONE -> phase=1, score=0, miss_count=0.
6. Reset mid-WINDOW with a coincident player_valid -> all outputs 0, phase=0, no right pulse.
7. BCD wrap (WIN_SCORE=12): ten hits -> score_tens=1, score_ones=0.

Source files
------------

// File: rtl/dance_round_ctrl_pkg.sv
// Shared definitions for the boss dance round sequencer:
// pose encodings, phase (FSM state) encodings and BCD digit width.
package dance_round_ctrl_pkg;

   // Same codes the boss pose generator drives on boss_pose.
   typedef enum logic [1:0] {
      POSE_DOWN    = 2'b00,
      POSE_RIGHTUP = 2'b01,
      POSE_LEFTUP  = 2'b10,
      POSE_UP      = 2'b11
   } pose_e;

   typedef enum logic [2:0] {
      PH_IDLE   = 3'd0,
      PH_SHOW   = 3'd1,
      PH_WINDOW = 3'd2,
      PH_RESULT = 3'd3,
      PH_DONE   = 3'd4
   } phase_e;

   localparam int BCD_W = 4;

endpackage

// File: rtl/dance_round_ctrl_if.sv
// Signal bundle between player decode / boss block and the round
// sequencer. master: drives start/pose inputs; slave: the sequencer.
interface dance_round_ctrl_if;
   import dance_round_ctrl_pkg::*;

   logic             start;
   logic             player_valid;
   logic [1:0]       player_pose;
   logic [1:0]       boss_pose;
   logic             right;
   logic             pose_advance;
   logic [BCD_W-1:0] score_ones;
   logic [BCD_W-1:0] score_tens;
   logic [1:0]       miss_count;
   logic [2:0]       phase;
   logic             game_over;
   logic             win;

   modport master (
      output start, player_valid, player_pose, boss_pose,
      input  right, pose_advance, score_ones, score_tens,
      input  miss_count, phase, game_over, win
   );

   modport slave (
      input  start, player_valid, player_pose, boss_pose,
      output right, pose_advance, score_ones, score_tens,
      output miss_count, phase, game_over, win
   );

endinterface

// File: rtl/dance_round_ctrl_tick_gen.sv
// Game tick divider: counts 0..TICK_DIV-1, tick high at TICK_DIV-1.
// Ports: clk, clr (sync clear, restarts the period), tick (1-cycle).
module tick_gen #(
   parameter int TICK_DIV = 100000
) (
   input  logic clk,
   input  logic clr,
   output logic tick
);
   localparam int CW = $clog2(TICK_DIV);

   logic [CW-1:0] cnt;

   assign tick = (cnt == CW'(TICK_DIV - 1));

   always_ff @(posedge clk) begin
      if (clr)
         cnt <= '0;
      else if (tick)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/dance_round_ctrl.sv
// Round sequencer for the boss dance game: show/window pacing, pose
// judging, BCD score, misses, win/game-over. Ports: clk, reset, bus.
module dance_round_ctrl
   import dance_round_ctrl_pkg::*;
#(
   parameter int TICK_DIV     = 100000,
   parameter int SHOW_TICKS   = 8,
   parameter int WINDOW_TICKS = 16,
   parameter int MAX_MISS     = 3,
   parameter int WIN_SCORE    = 99
) (
   input  logic               clk,
   input  logic               reset,
   dance_round_ctrl_if.slave  bus
);
   localparam int TMAX = (SHOW_TICKS > WINDOW_TICKS) ?
                         SHOW_TICKS : WINDOW_TICKS;
   localparam int TW = $clog2(TMAX + 1);

   localparam logic [BCD_W-1:0] WIN_T = BCD_W'(WIN_SCORE / 10);
   localparam logic [BCD_W-1:0] WIN_O = BCD_W'(WIN_SCORE % 10);
   localparam logic [1:0]       MISS_LIM = 2'(MAX_MISS);

   phase_e state_q, state_d;

   logic          tick;
   logic          enter;
   logic [TW-1:0] tcnt_q;

   logic clr_game, hit, miss, adv, set_win;

   logic [BCD_W-1:0] ones_q, tens_q;
   logic [1:0]       miss_q;
   logic             right_q, adv_q, win_q;

   logic match, show_end, win_end, score_win;

   assign match     = (bus.player_pose == bus.boss_pose);
   assign show_end  = tick && (tcnt_q == TW'(SHOW_TICKS - 1));
   assign win_end   = tick && (tcnt_q == TW'(WINDOW_TICKS - 1));
   assign score_win = (tens_q == WIN_T) && (ones_q == WIN_O);

   // Divider restarts on every state entry so each state's
   // first tick lands a full TICK_DIV cycles after entry.
   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk  (clk),
      .clr  (reset | enter),
      .tick (tick)
   );

   always_ff @(posedge clk) begin
      if (reset)
         state_q <= PH_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      clr_game = 1'b0;
      hit      = 1'b0;
      miss     = 1'b0;
      adv      = 1'b0;
      set_win  = 1'b0;
      if (bus.start) begin
         state_d  = PH_SHOW;
         clr_game = 1'b1;
      end else begin
         unique case (state_q)
            PH_IDLE: ;
            PH_SHOW:
               if (show_end)
                  state_d = PH_WINDOW;
            PH_WINDOW:
               // A response on the timeout tick still counts.
               if (bus.player_valid) begin
                  state_d = PH_RESULT;
                  hit     = match;
                  miss    = !match;
               end else if (win_end) begin
                  state_d = PH_RESULT;
                  miss    = 1'b1;
               end
            PH_RESULT: begin
               adv = 1'b1;
               if (score_win) begin
                  state_d = PH_DONE;
                  set_win = 1'b1;
               end else if (miss_q == MISS_LIM) begin
                  state_d = PH_DONE;
               end else begin
                  state_d = PH_SHOW;
               end
            end
            PH_DONE: ;
            default: state_d = PH_IDLE;
         endcase
      end
      enter = (state_d != state_q) || clr_game;
   end

   always_ff @(posedge clk) begin
      if (reset || enter)
         tcnt_q <= '0;
      else if (tick)
         tcnt_q <= tcnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ones_q  <= '0;
         tens_q  <= '0;
         miss_q  <= '0;
         right_q <= 1'b0;
         adv_q   <= 1'b0;
         win_q   <= 1'b0;
      end else begin
         right_q <= hit;
         adv_q   <= adv;
         if (clr_game) begin
            ones_q <= '0;
            tens_q <= '0;
            miss_q <= '0;
            win_q  <= 1'b0;
         end else begin
            // Score saturates at 99.
            if (hit && !(tens_q == 4'd9 && ones_q == 4'd9)) begin
               if (ones_q == 4'd9) begin
                  ones_q <= '0;
                  tens_q <= tens_q + 4'd1;
               end else begin
                  ones_q <= ones_q + 4'd1;
               end
            end
            if (miss && miss_q != 2'd3)
               miss_q <= miss_q + 2'd1;
            if (set_win)
               win_q <= 1'b1;
         end
      end
   end

   assign bus.right        = right_q;
   assign bus.pose_advance = adv_q;
   assign bus.score_ones   = ones_q;
   assign bus.score_tens   = tens_q;
   assign bus.miss_count   = miss_q;
   assign bus.phase        = state_q;
   assign bus.game_over    = (state_q == PH_DONE);
   assign bus.win          = win_q;

endmodule
